// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider.
// Minimum legal ratio, default width, ratio type, half-ratio helper.
package clk_div_pkg;

  localparam int DIV_W_DEF = 8;
  localparam int DIV_MIN   = 2;

  typedef logic [DIV_W_DEF-1:0] ratio_t;

  function automatic int unsigned half(input int unsigned n);
    return n >> 1;
  endfunction

endpackage

// File: rtl/clk_div_negstage.sv
// Falling-edge retiming flop for the odd-ratio half-period extension.
// Ports: clk, rst_n (async active-low), d in, q out.
module clk_div_negstage (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider, 50% duty for odd and even N.
// Ports: clk, rst_n, en, div_load/div_val in; div_ack, div_err, out_clk, out_tick out.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DIV_DEFAULT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_val,
  output logic             div_ack,
  output logic             div_err,
  output logic             out_clk,
  output logic             out_tick
);

  typedef logic [DIV_W-1:0] div_t;

  localparam div_t DEF = div_t'(DIV_DEFAULT);
  localparam div_t MIN = div_t'(DIV_MIN);
  localparam div_t ONE = div_t'(1);

  div_t div_cur;
  div_t cnt;
  div_t pend_val;
  logic pend;
  logic out_p;
  logic out_n;

  logic wrap;
  logic apply;
  div_t cnt_nxt;
  div_t div_new;
  div_t h_new;

  assign wrap    = (cnt == div_cur - ONE);
  assign cnt_nxt = wrap ? '0 : cnt + ONE;
  // A pending ratio only lands on a period boundary.
  assign apply   = pend & (cnt_nxt == '0);
  assign div_new = (en & apply) ? pend_val : div_cur;
  assign h_new   = div_t'(half(32'(div_new)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cur  <= DEF;
      cnt      <= DEF - ONE;
      pend     <= 1'b0;
      pend_val <= DEF;
      out_p    <= 1'b0;
      out_tick <= 1'b0;
      div_ack  <= 1'b0;
      div_err  <= 1'b0;
    end else begin
      div_ack <= 1'b0;
      div_err <= 1'b0;
      if (en) begin
        cnt      <= cnt_nxt;
        out_p    <= (cnt_nxt < h_new);
        out_tick <= (cnt_nxt == '0);
        if (apply) begin
          div_cur <= pend_val;
          pend    <= 1'b0;
          div_ack <= 1'b1;
        end
      end else begin
        out_p    <= 1'b0;
        out_tick <= 1'b0;
        if (pend) begin
          div_cur <= pend_val;
          cnt     <= pend_val - ONE;
          pend    <= 1'b0;
          div_ack <= 1'b1;
        end else begin
          cnt <= div_cur - ONE;
        end
      end
      // A new request overrides the pending flag cleared by an apply above.
      if (div_load) begin
        if (div_val < MIN) begin
          div_err <= 1'b1;
        end else begin
          pend     <= 1'b1;
          pend_val <= div_val;
        end
      end
    end
  end

  clk_div_negstage u_neg (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (out_p & div_cur[0]),
    .q     (out_n)
  );

  assign out_clk = out_p | out_n;

endmodule
